// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared timing defaults, text geometry and cell-address helper
package vga_text_pkg;

    localparam int H_VIS_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int V_VIS_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    localparam int TEXT_COLS = 80;
    localparam int TEXT_ROWS = 30;
    localparam int CELL_W    = 8;
    localparam int CELL_H    = 16;
    localparam logic [7:0] CHR_SPACE = 8'h20;

    // Counter width leaves headroom for timings well beyond 800x525.
    localparam int CNT_W  = 12;
    localparam int ADDR_W = 12;

    // Cell index of the character covering pixel (hc, vc): row*TEXT_COLS + column.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [CNT_W-1:0] hc,
                                                    input logic [CNT_W-1:0] vc);
        logic [ADDR_W-1:0] cell_row;
        logic [ADDR_W-1:0] cell_col;
        cell_row = ADDR_W'(vc >> $clog2(CELL_H));
        cell_col = ADDR_W'(hc >> $clog2(CELL_W));
        return ADDR_W'(cell_row * ADDR_W'(TEXT_COLS)) + cell_col;
    endfunction

endpackage

// File: rtl/vga_text_fetch_if.sv
// rtl/vga_text_fetch_if.sv - text-buffer read port and glyph-stage output bundle
interface vga_text_fetch_if;
    import vga_text_pkg::*;

    logic [ADDR_W-1:0] text_addr;
    logic [7:0]        text_data;
    logic [7:0]        chr_val;
    logic [3:0]        row;
    logic [2:0]        col;
    logic [7:0]        pixel_mask;
    logic              active;
    logic              hsync;
    logic              vsync;
    logic              frame_start;

    modport master (
        output text_addr, chr_val, row, col, pixel_mask, active, hsync, vsync, frame_start,
        input  text_data
    );

    modport slave (
        input  text_addr, chr_val, row, col, pixel_mask, active, hsync, vsync, frame_start,
        output text_data
    );

endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - horizontal/vertical counters with raw visible, sync and origin flags
module vga_timing
    import vga_text_pkg::*;
#(
    parameter int H_VIS  = H_VIS_DEF,
    parameter int H_FP   = H_FP_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP   = H_BP_DEF,
    parameter int V_VIS  = V_VIS_DEF,
    parameter int V_FP   = V_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP   = V_BP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             visible,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             origin
);

    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);

    // Raster position: hcount wraps every line, vcount steps on that wrap and wraps per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_en) begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + CNT_W'(1);
            end else begin
                hcount <= hcount + CNT_W'(1);
            end
        end
    end

    assign visible   = (hcount < H_VIS_C) && (vcount < V_VIS_C);
    assign hsync_raw = !((hcount >= HS_START) && (hcount < HS_END));
    assign vsync_raw = !((vcount >= VS_START) && (vcount < VS_END));
    assign origin    = (hcount == '0) && (vcount == '0);

endmodule

// File: rtl/vga_text_fetch.sv
// rtl/vga_text_fetch.sv - two-stage text-cell fetch pipeline aligned with VGA timing
module vga_text_fetch
    import vga_text_pkg::*;
#(
    parameter int H_VIS  = H_VIS_DEF,
    parameter int H_FP   = H_FP_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP   = H_BP_DEF,
    parameter int V_VIS  = V_VIS_DEF,
    parameter int V_FP   = V_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP   = V_BP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en,
    vga_text_fetch_if.master  bus
);

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             visible;
    logic             hsync_raw;
    logic             vsync_raw;
    logic             origin;

    // Pixel attributes travelling alongside the outstanding text-buffer read.
    logic [2:0] s1_hpix;
    logic [3:0] s1_vrow;
    logic       s1_vis;
    logic       s1_hs;
    logic       s1_vs;
    logic       s1_fs;

    vga_timing #(
        .H_VIS (H_VIS),
        .H_FP  (H_FP),
        .H_SYNC(H_SYNC),
        .H_BP  (H_BP),
        .V_VIS (V_VIS),
        .V_FP  (V_FP),
        .V_SYNC(V_SYNC),
        .V_BP  (V_BP)
    ) u_timing (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_en   (pix_en),
        .hcount   (hcount),
        .vcount   (vcount),
        .visible  (visible),
        .hsync_raw(hsync_raw),
        .vsync_raw(vsync_raw),
        .origin   (origin)
    );

    // First stage: issue the cell read and latch the attributes that pair with its data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.text_addr <= '0;
            s1_hpix       <= '0;
            s1_vrow       <= '0;
            s1_vis        <= 1'b0;
            s1_hs         <= 1'b1;
            s1_vs         <= 1'b1;
            s1_fs         <= 1'b0;
        end else if (pix_en) begin
            bus.text_addr <= visible ? cell_addr(hcount, vcount) : '0;
            s1_hpix       <= hcount[2:0];
            s1_vrow       <= vcount[3:0];
            s1_vis        <= visible;
            s1_hs         <= hsync_raw;
            s1_vs         <= vsync_raw;
            s1_fs         <= origin;
        end
    end

    // Second stage: combine returned character with glyph coordinates; blanking shows a space.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.chr_val     <= CHR_SPACE;
            bus.row         <= '0;
            bus.col         <= 3'd7;
            bus.pixel_mask  <= '0;
            bus.active      <= 1'b0;
            bus.hsync       <= 1'b1;
            bus.vsync       <= 1'b1;
            bus.frame_start <= 1'b0;
        end else if (pix_en) begin
            if (s1_vis) begin
                bus.chr_val    <= bus.text_data;
                bus.row        <= s1_vrow;
                bus.col        <= 3'd7 - s1_hpix;
                bus.pixel_mask <= 8'b1 << (3'd7 - s1_hpix);
                bus.active     <= 1'b1;
            end else begin
                bus.chr_val    <= CHR_SPACE;
                bus.row        <= '0;
                bus.col        <= 3'd7;
                bus.pixel_mask <= '0;
                bus.active     <= 1'b0;
            end
            bus.hsync       <= s1_hs;
            bus.vsync       <= s1_vs;
            bus.frame_start <= s1_fs;
        end
    end

endmodule

// File: tb/tb_vga_text_fetch.sv
// tb/tb_vga_text_fetch.sv - randomized-enable bench with raster-level reference model
module tb_vga_text_fetch;

    localparam int HV = 40;
    localparam int HF = 4;
    localparam int HS = 8;
    localparam int HB = 4;
    localparam int VV = 40;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  chr;
        logic [3:0]  row;
        logic [2:0]  col;
        logic [7:0]  mask;
        logic        act;
        logic        hs;
        logic        vs;
        logic        fs;
    } exp_t;

    logic clk;
    logic rst_n;
    logic pix_en;
    logic [7:0] key;
    int n;
    int checks;
    int failures;
    int phase;
    int hits;
    int hlow;
    int vlow;
    int fs_q[$];

    vga_text_fetch_if bus ();

    vga_text_fetch #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pix_en(pix_en),
        .bus   (bus)
    );

    function automatic logic [7:0] mem_byte(input logic [11:0] a);
        return a[7:0] ^ key;
    endfunction

    assign bus.text_data = mem_byte(bus.text_addr);

    // Expected outputs after nn enabled ticks since reset release.
    function automatic exp_t model(input int nn);
        exp_t e;
        int p, x, y;
        e = {12'd0, 8'h20, 4'd0, 3'd7, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        if (nn >= 1) begin
            p = (nn - 1) % FRAME; x = p % HT; y = p / HT;
            if (x < HV && y < VV) e.addr = 12'((y / 16) * 80 + x / 8);
        end
        if (nn >= 2) begin
            p = (nn - 2) % FRAME; x = p % HT; y = p / HT;
            if (x < HV && y < VV) begin
                e.chr  = mem_byte(12'((y / 16) * 80 + x / 8));
                e.row  = 4'(y % 16);
                e.col  = 3'(7 - x % 8);
                e.mask = 8'(1 << (7 - x % 8));
                e.act  = 1'b1;
            end
            e.hs = !(x >= HV + HF && x < HV + HF + HS);
            e.vs = !(y >= VV + VF && y < VV + VF + VS);
            e.fs = (x == 0 && y == 0);
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic exp_t sample();
        return {bus.text_addr, bus.chr_val, bus.row, bus.col, bus.pixel_mask,
                bus.active, bus.hsync, bus.vsync, bus.frame_start};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Enabled-tick counter since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else if (pix_en) n <= n + 1;
    end

    // Compare process: every negedge against the model, plus per-epoch statistics.
    initial begin
        exp_t a, e;
        int last_n;
        last_n = 0;
        forever begin
            @(negedge clk);
            a = sample();
            e = model(n);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL cycle_model n=%0d actual=%h expected=%h", n, a, e);
            end
            if (!rst_n) begin
                hlow = 0; vlow = 0; fs_q.delete(); last_n = 0;
            end else if (n != last_n) begin
                last_n = n;
                if (n >= 2 && n < 2 + HT && !bus.hsync) hlow++;
                if (n >= 2 && n < 2 + FRAME && !bus.vsync) vlow++;
                if (bus.frame_start) fs_q.push_back(n);
                if (phase == 0) begin
                    case (n)
                        42: begin
                            hits++;
                            chk("blank_active", int'(bus.active), 0);
                            chk("blank_chr", int'(bus.chr_val), 32);
                            chk("blank_mask", int'(bus.pixel_mask), 0);
                        end
                        1979: begin
                            hits++;
                            chk("px17_35_chr", int'(bus.chr_val), 162);
                            chk("px17_35_row", int'(bus.row), 3);
                            chk("px17_35_col", int'(bus.col), 6);
                            chk("px17_35_mask", int'(bus.pixel_mask), 8'h40);
                        end
                        2224: begin
                            hits++;
                            chk("last_cell_addr", int'(bus.text_addr), 164);
                        end
                        2225: begin
                            hits++;
                            chk("last_px_col", int'(bus.col), 0);
                            chk("last_px_mask", int'(bus.pixel_mask), 1);
                            chk("last_px_chr", int'(bus.chr_val), 164);
                            chk("last_px_active", int'(bus.active), 1);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic run_until(input int target, input int mode, input int budget);
        int cyc;
        cyc = 0;
        while (n < target && cyc < budget) begin
            @(posedge clk);
            #2;
            case (mode)
                0: pix_en = ($urandom_range(0, 3) != 0);
                1: pix_en = ~pix_en;
                default: pix_en = 1'b1;
            endcase
            cyc++;
        end
        chk("run_within_budget", int'(n >= target), 1);
    endtask

    task automatic epoch_stats();
        chk("hsync_low_ticks", hlow, HS);
        chk("vsync_low_ticks", vlow, VS * HT);
        chk("frame_start_count", fs_q.size(), 2);
        chk("frame_start_first", (fs_q.size() > 0) ? fs_q[0] : -1, 2);
        chk("frame_start_second", (fs_q.size() > 1) ? fs_q[1] : -1, 2 + FRAME);
    endtask

    initial begin
        exp_t e, rst_val;
        checks = 0; failures = 0; phase = 0; hits = 0;
        hlow = 0; vlow = 0;
        rst_n = 1'b0; pix_en = 1'b0; key = 8'h00;
        rst_val = {12'd0, 8'h20, 4'd0, 3'd7, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0};

        // Hand-computed pins on the model itself.
        e = model(1979);
        chk("model_chr", int'(e.chr), 162);
        chk("model_row", int'(e.row), 3);
        chk("model_col", int'(e.col), 6);
        chk("model_mask", int'(e.mask), 8'h40);
        e = model(2);
        chk("model_fs", int'(e.fs), 1);
        e = model(2 + 44);
        chk("model_hs_start", int'(e.hs), 0);
        e = model(2 + 43);
        chk("model_hs_before", int'(e.hs), 1);

        repeat (3) @(posedge clk);
        #2;
        chk("reset_state", int'(sample() == rst_val), 1);
        rst_n = 1'b1;

        // Random enable over a full frame plus margin.
        run_until(FRAME + 40, 0, 8000);
        chk("literal_points_hit", hits, 4);
        epoch_stats();

        // Alternating enable into mid-frame, then asynchronous reset pulse.
        phase = 1;
        run_until(1200, 1, 4000);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_values", int'(sample() == rst_val), 1);
        key = 8'($urandom);
        repeat (3) @(posedge clk);
        #2;
        pix_en = 1'b1;
        rst_n = 1'b1;
        run_until(FRAME + 70, 2, 4000);
        epoch_stats();

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_text_fetch.md
VGA_TEXT_FETCH -- requirements
Module: vga_text_fetch

Interface
REQ-001 Parameter H_VIS, default 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_VIS, default 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 clk  in  1  system clock, the single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 pix_en  in  1  pixel-tick enable; the block advances only on clk edges where pix_en=1.
REQ-008 text_addr  out  12  text-buffer read address, cell index row*80+column.
REQ-009 text_data  in  8  text-buffer byte, valid exactly one pixel tick after text_addr.
REQ-010 chr_val  out  8  character code for the downstream glyph-ROM stage.
REQ-011 row  out  4  glyph scanline within the cell, 0..15.
REQ-012 col  out  3  glyph bit index, 7 at the leftmost pixel and 0 at the rightmost.
REQ-013 pixel_mask  out  8  one-hot select of glyph bit col; 0 during blanking.
REQ-014 active, hsync, vsync, frame_start  out  1 each  stage-2 aligned display-enable, active-low syncs, and frame pulse.

Function
REQ-015 hcount SHALL count 0..H_TOTAL-1, with H_TOTAL=H_VIS+H_FP+H_SYNC+H_BP=800, and wrap to 0; vcount SHALL increment on each hcount wrap, counting 0..524, and wrap to 0.
REQ-016 When pix_en=0, every counter, pipeline register and output SHALL hold its value.
REQ-017 Stage 0: text_addr SHALL be registered as (vcount>>4)*80 + (hcount>>3) while hcount<H_VIS and vcount<V_VIS, and 0 otherwise.
REQ-018 Stage 1: the block SHALL capture text_data together with the stage-0 hcount[2:0], vcount[3:0] and visible flag.
REQ-019 Stage 2 outputs SHALL update two pix_en ticks after the counter value that produced them, all mutually aligned.
REQ-020 Stage 2, visible: chr_val=text_data, row=vcount[3:0], col=7-hcount[2:0], pixel_mask=8'b1<<col, active=1.
REQ-021 Stage 2, blanking: chr_val=8'h20 (space), row=0, col=7, pixel_mask=0, active=0.
REQ-022 hsync SHALL be 0 while H_VIS+H_FP <= hcount < H_VIS+H_FP+H_SYNC, and 1 otherwise; vsync SHALL follow the same rule on vcount with the V parameters. Both SHALL be delayed to stage-2 alignment.
REQ-023 frame_start SHALL be 1 for exactly one pix_en tick, the tick on which stage 2 presents hcount=0, vcount=0.
REQ-024 Simultaneous hcount and vcount wrap (799, 524) SHALL return both counters to (0, 0) on the same tick.
REQ-025 text_addr SHALL never exceed 2399.

Reset
REQ-026 While rst_n=0: hcount=vcount=0, pipeline flushed, text_addr=0, chr_val=8'h20, row=0, col=7, pixel_mask=0, active=0, hsync=1, vsync=1, frame_start=0.
REQ-027 Deassertion mid-frame SHALL restart at (0, 0); the first frame_start SHALL occur on the second pix_en tick after release.

Structure
REQ-028 Package vga_text_pkg SHALL hold the default timing constants, TEXT_COLS=80, TEXT_ROWS=30, CELL_W=8, CELL_H=16 and CHR_SPACE=8'h20.
REQ-029 The counters and raw sync generation SHALL live in sub-module vga_timing; vga_text_fetch SHALL hold the two pipeline stages.

Verification
REQ-030 Reset, then pix_en=1 continuously -> hsync low for exactly 96 ticks per 800-tick line; vsync low for exactly 2 lines per 525-line frame.
REQ-031 Memory model returning addr[7:0] -> at stage 2 for pixel (x=17, y=35): chr_val=8'd162 (addr 2*80+2), row=3, col=6, pixel_mask=8'h40.
REQ-032 pix_en toggling 1-0-1-0 -> outputs identical to a continuous-enable run after compressing out the idle cycles.
REQ-033 Stage 2 at hcount=640 on any line -> active=0, chr_val=8'h20, pixel_mask=0; last visible cell (x=639, y=479) -> text_addr=2399, col=0, pixel_mask=8'h01.
REQ-034 rst_n pulsed low at line 200 -> all outputs at reset values asynchronously; frame_start exactly once, 2 ticks after release, then every 420000 ticks.
